// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick scheduler: channel mode/state encodings
// and the prescaler divide-ratio calculation.
package tick_pkg;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  // Clocks per base tick; callers must keep the result at 2 or more.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Requester-side bus of the tick scheduler: channel configuration, per-channel
// start/stop requests and the busy/expire/base_tick status returned to requesters.
interface tick_sched_if #(
  parameter int NCH = 4,
  parameter int PW  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          cfg_mode;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] expire;
  logic          base_tick;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop,
    input  busy, expire, base_tick
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop,
    output busy, expire, base_tick
  );

endinterface

// File: rtl/tick_channel.sv
// One down-counting timer channel: holds its period/mode, counts base ticks while
// running and emits a one-cycle expire pulse when the period elapses.
module tick_channel
  import tick_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          start,
  input  logic          stop,
  input  logic          tick,
  output logic          busy,
  output logic          expire
);

  chan_state_t   state, state_n;
  mode_t         mode_r;
  logic [PW-1:0] period_r;
  logic [PW-1:0] cnt, cnt_n;
  logic          expire_n;
  logic          period_ok;

  assign period_ok = (period_r != '0);

  // NOTE: every register here is written with <= so all flops update from the
  // same pre-edge values; blocking assignments would make the order of statements matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      expire   <= 1'b0;
      period_r <= '0;
      mode_r   <= ONESHOT;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      expire <= expire_n;
      // Loads in this same edge still see the old period_r.
      if (cfg_we) begin
        period_r <= cfg_period;
        mode_r   <= mode_t'(cfg_mode);
      end
    end
  end

  // NOTE: all outputs of this block get a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    expire_n = 1'b0;

    if (stop) begin
      state_n = IDLE;
    end else if (start && period_ok) begin
      state_n = RUN;
      cnt_n   = period_r;
    end else if (state == RUN && tick) begin
      if (cnt == PW'(1)) begin
        expire_n = 1'b1;
        // A period cleared to zero while running ends the channel instead of
        // loading a zero count that would never expire.
        if (mode_r == PERIODIC && period_ok) begin
          cnt_n = period_r;
        end else begin
          state_n = IDLE;
        end
      end else begin
        cnt_n = cnt - PW'(1);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: rtl/tick_sched.sv
// Multi-channel event timer: one shared prescaler produces base_tick, and NCH
// independent tick_channel instances time their periods off it.
module tick_sched
  import tick_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int PW      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  tick_sched_if.slave  bus
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (DIV < 2) begin : g_div_check
    $error("tick_sched: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PCW-1:0] pcnt;
  logic           base_tick_r;
  logic           pcnt_wrap;

  assign pcnt_wrap = (pcnt == PCW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      base_tick_r <= 1'b0;
    end else begin
      base_tick_r <= pcnt_wrap;
      pcnt        <= pcnt_wrap ? '0 : pcnt + PCW'(1);
    end
  end

  logic [NCH-1:0] cfg_sel;
  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] expire_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign cfg_sel[i] = bus.cfg_we && (bus.cfg_ch == CW'(i));

    tick_channel #(
      .PW(PW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_sel[i]),
      .cfg_period (bus.cfg_period),
      .cfg_mode   (bus.cfg_mode),
      .start      (bus.start[i]),
      .stop       (bus.stop[i]),
      .tick       (base_tick_r),
      .busy       (busy_w[i]),
      .expire     (expire_w[i])
    );
  end

  assign bus.busy      = busy_w;
  assign bus.expire    = expire_w;
  assign bus.base_tick = base_tick_r;

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched with DIV=10, NCH=4: directed stimulus pushes the
// edge at which each expire is due, and a negedge monitor pops and compares.
module tb_tick_sched;
  import tick_pkg::*;

  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_sched_if #(.NCH(NCH), .PW(PW)) bus ();

  tick_sched #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .NCH    (NCH),
    .PW     (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   last_edge = 0;
  int   exp_q[NCH][$];
  logic tb_periodic[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rising edges since the last reset release; reads as edge k in the cycle after edge k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    check("base_tick_phase", {31'b0, bus.base_tick},
          {31'b0, (rst_n && edge_n != 0 && (edge_n % DIV) == 0)});
    for (int i = 0; i < NCH; i++) begin
      if (bus.expire[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_expire_ch%0d", i), {31'b0, bus.expire[i]}, 32'd0);
        end else begin
          check($sformatf("expire_edge_ch%0d", i), edge_n, exp_q[i].pop_front());
          check($sformatf("busy_at_expire_ch%0d", i), {31'b0, bus.busy[i]}, {31'b0, tb_periodic[i]});
        end
      end
    end
  end

  // Drives one cycle of requests; last_edge is the edge that sampled them.
  task automatic drive(input logic [NCH-1:0] st, input logic [NCH-1:0] sp,
                       input logic we = 1'b0, input int ch = 0,
                       input int per = 0, input logic md = 1'b0);
    bus.start      = st;
    bus.stop       = sp;
    bus.cfg_we     = we;
    bus.cfg_ch     = ch[1:0];
    bus.cfg_period = per[PW-1:0];
    bus.cfg_mode   = md;
    @(posedge clk);
    #1;
    last_edge  = edge_n;
    bus.start  = '0;
    bus.stop   = '0;
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg(input int ch, input int per, input logic md);
    drive('0, '0, 1'b1, ch, per, md);
    tb_periodic[ch] = md;
  endtask

  // Returns at the negedge of the cycle in which base_tick is high.
  task automatic wait_tick();
    logic got = 1'b0;
    for (int n = 0; n < 2 * DIV && !got; n++) begin
      @(negedge clk);
      got = bus.base_tick;
    end
    if (!got) check("wait_tick_timeout", {31'b0, bus.base_tick}, 32'd1);
  endtask

  task automatic wait_drain(input int ch, input int budget);
    for (int n = 0; n < budget && exp_q[ch].size() != 0; n++) @(negedge clk);
    if (exp_q[ch].size() != 0) begin
      check($sformatf("drain_timeout_ch%0d", ch), exp_q[ch].size(), 32'd0);
      exp_q[ch].delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.start = '0; bus.stop = '0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_mode = 1'b0;
    for (int i = 0; i < NCH; i++) tb_periodic[i] = 1'b0;

    // Reset state and first base_tick
    repeat (3) @(negedge clk);
    check("rst_busy", {28'b0, bus.busy}, 32'd0);
    check("rst_expire", {28'b0, bus.expire}, 32'd0);
    check("rst_base_tick", {31'b0, bus.base_tick}, 32'd0);
    rst_n = 1'b1;
    wait_tick();
    check("first_tick_edge", edge_n, 32'd10);
    repeat (25) @(negedge clk);
    check("idle_busy", {28'b0, bus.busy}, 32'd0);

    // ch0 one-shot, period 3: start one cycle after the tick, then coincident with it
    cfg(0, 3, 1'b0);
    wait_tick();
    @(posedge clk); #1;
    drive(4'b0001, '0);
    exp_q[0].push_back(last_edge + 29);
    check("ch0_busy_after_start", {31'b0, bus.busy[0]}, 32'd1);
    wait_drain(0, 60);
    wait_tick();
    drive(4'b0001, '0);
    exp_q[0].push_back(last_edge + 30);
    wait_drain(0, 60);
    check("ch0_idle_after_expire", {31'b0, bus.busy[0]}, 32'd0);

    // ch1 periodic, period 2, then stop between pulses
    cfg(1, 2, 1'b1);
    wait_tick();
    @(posedge clk); #1;
    drive(4'b0010, '0);
    exp_q[1].push_back(last_edge + 19);
    exp_q[1].push_back(last_edge + 39);
    wait_drain(1, 80);
    drive('0, 4'b0010);
    check("ch1_stop_busy", {31'b0, bus.busy[1]}, 32'd0);
    repeat (50) @(negedge clk);
    check("ch1_still_idle", {31'b0, bus.busy[1]}, 32'd0);

    // ch2: start+stop together, then stop on the expiring edge
    cfg(2, 5, 1'b0);
    drive(4'b0100, 4'b0100);
    check("ch2_start_stop_idle", {31'b0, bus.busy[2]}, 32'd0);
    cfg(2, 1, 1'b0);
    wait_tick();
    drive(4'b0100, '0);
    check("ch2_running", {31'b0, bus.busy[2]}, 32'd1);
    wait_tick();
    drive('0, 4'b0100);
    check("ch2_stop_on_expire", {31'b0, bus.busy[2]}, 32'd0);
    repeat (30) @(negedge clk);

    // ch3 periodic 4, reconfigured to 1 while running
    cfg(3, 4, 1'b1);
    wait_tick();
    drive(4'b1000, '0);
    s = last_edge;
    drive('0, '0, 1'b1, 3, 1, 1'b1);
    exp_q[3].push_back(s + 40);
    exp_q[3].push_back(s + 50);
    exp_q[3].push_back(s + 60);
    wait_drain(3, 100);
    drive('0, 4'b1000);
    check("ch3_stopped", {31'b0, bus.busy[3]}, 32'd0);

    // cfg and start together load the old period; a zero period then blocks start
    wait_tick();
    drive(4'b1000, '0, 1'b1, 3, 0, 1'b0);
    tb_periodic[3] = 1'b0;
    exp_q[3].push_back(last_edge + 10);
    check("ch3_old_period_load", {31'b0, bus.busy[3]}, 32'd1);
    wait_drain(3, 40);
    drive(4'b1000, '0);
    check("ch3_zero_period_ignored", {31'b0, bus.busy[3]}, 32'd0);

    // Asynchronous reset in the middle of counting on every channel
    cfg(0, 5, 1'b1);
    cfg(1, 4, 1'b0);
    cfg(2, 3, 1'b0);
    cfg(3, 6, 1'b1);
    drive(4'b1111, '0);
    check("all_busy", {28'b0, bus.busy}, 32'hF);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {28'b0, bus.busy}, 32'd0);
    check("async_rst_expire", {28'b0, bus.expire}, 32'd0);
    check("async_rst_base_tick", {31'b0, bus.base_tick}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_busy", {28'b0, bus.busy}, 32'd0);

    for (int i = 0; i < NCH; i++)
      check($sformatf("queue_empty_ch%0d", i), exp_q[i].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
